nc_frame_loader: RTL and testbench

- Upstream stage of the 128-entry FFT input shift FIFO.
- Accepts a stream of signed audio samples over a valid/ready handshake and packs each into a DWIDTH-bit complex word: real part is the sample, imaginary part is zero.
- Writes exactly FRAME_LEN words per frame into the FIFO using its wr_ce/data_in interface.
- Holds off writing until the FFT reports completion (fft_edone), then starts the next frame.

---
 rtl/nc_pkg.sv | 30 +++
 rtl/nc_hist_buf.sv | 57 +++++
 rtl/nc_frame_loader.sv | 192 +++++++++++++++++++
 tb/tb_nc_frame_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nc_pkg.sv
// ============================================================================
// Module  : nc_pkg
// Brief   : Shared state encoding, frame constant and sample packing helper
//           for the FFT frame loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nc_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        WAIT   = 2'd1,
        REPLAY = 2'd2
    } nc_state_t;

    localparam int NC_FRAME_LEN = 128;
    localparam int NC_DWIDTH    = 32;
    localparam int NC_SWIDTH    = 16;

    // Real part = sign-extended sample in the upper half, imaginary part = 0.
    function automatic logic [NC_DWIDTH-1:0] nc_pack_sample(input logic [NC_SWIDTH-1:0] s);
        logic signed [NC_DWIDTH/2-1:0] re;
        re = (NC_DWIDTH/2)'($signed(s));
        return {re, {(NC_DWIDTH/2){1'b0}}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/nc_hist_buf.sv
// ============================================================================
// Module  : nc_hist_buf
// Brief   : Circular DEPTH x DWIDTH register buffer holding the tail of the
//           previous frame; read back oldest-first from the write pointer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nc_hist_buf #(
    parameter int DEPTH  = 64,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_start,
    input  logic              i_rd_adv,
    output logic [DWIDTH-1:0] o_rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_wr_en)
                r_wptr <= ptr_inc(r_wptr);
            // Once full, the write pointer always points at the oldest entry.
            if (i_rd_start)
                r_rptr <= r_wptr;
            else if (i_rd_adv)
                r_rptr <= ptr_inc(r_rptr);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/nc_frame_loader.sv
// ============================================================================
// Module  : nc_frame_loader
// Brief   : Packs a valid/ready sample stream into complex words and writes
//           one FFT frame at a time into the input FIFO.
//           Optional overlap replay enabled by NC_FRAME_OVERLAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nc_frame_loader
    import nc_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int SWIDTH    = 16,
    parameter int FRAME_LEN = NC_FRAME_LEN,
    parameter int HOP       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [SWIDTH-1:0] in_data,
    output logic              in_ready,
    input  logic              fifo_full,
    input  logic              fifo_error,
    input  logic              fft_edone,
    output logic              wr_ce,
    output logic [DWIDTH-1:0] wr_data,
    output logic              frame_rdy,
    output logic [7:0]        frame_seq,
    output logic              err
);

    localparam logic [7:0] c_FRAME_LAST = 8'(FRAME_LEN - 1);
    localparam logic [8:0] c_FRAME_LEN9 = 9'(FRAME_LEN);

    generate
        if (HOP >= FRAME_LEN) begin : g_chk_hop
            $error("HOP must be smaller than FRAME_LEN");
        end
        if (SWIDTH > DWIDTH/2) begin : g_chk_swidth
            $error("SWIDTH must not exceed DWIDTH/2");
        end
    endgenerate

    nc_state_t         r_state;
    nc_state_t         w_state_nxt;
    logic [7:0]        r_wcnt;
    logic              r_run;
    logic              r_wr_ce;
    logic [DWIDTH-1:0] r_wr_data;
    logic              r_full_seen;
    logic [7:0]        r_seq;
    logic              r_err;
    logic [DWIDTH-1:0] w_pack;
    logic [DWIDTH-1:0] w_hist_data;
    logic              w_ready;
    logic              w_accept;
    logic              w_rep_issue;
    logic              w_edone_ok;

    generate
        if (DWIDTH == NC_DWIDTH && SWIDTH == NC_SWIDTH) begin : g_pack_pkg
            assign w_pack = nc_pack_sample(in_data);
        end else begin : g_pack_gen
            logic signed [DWIDTH/2-1:0] w_re;
            assign w_re   = (DWIDTH/2)'($signed(in_data));
            assign w_pack = {w_re, {(DWIDTH/2){1'b0}}};
        end
    endgenerate

`ifdef NC_FRAME_OVERLAP_EN
    localparam int         HDEPTH   = FRAME_LEN - HOP;
    localparam logic [7:0] c_HDEPTH = 8'(HDEPTH);

    logic       r_hist_valid;
    logic [7:0] r_rcnt;
    logic       w_rep_start;

    nc_hist_buf #(
        .DEPTH  (HDEPTH),
        .DWIDTH (DWIDTH)
    ) u_hist (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_accept),
        .i_wr_data  (w_pack),
        .i_rd_start (w_rep_start),
        .i_rd_adv   (w_rep_issue),
        .o_rd_data  (w_hist_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist_valid <= 1'b0;
            r_rcnt       <= '0;
        end else begin
            if (w_rep_start)
                r_rcnt <= '0;
            else if (w_rep_issue)
                r_rcnt <= r_rcnt + 1'b1;
            if (r_state == FILL && w_state_nxt == WAIT)
                r_hist_valid <= 1'b1;
        end
    end
`else
    assign w_hist_data = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_rep_issue = 1'b0;
`ifdef NC_FRAME_OVERLAP_EN
        w_rep_start = 1'b0;
`endif
        case (r_state)
            FILL: begin
                // The write already in flight counts against the frame length.
                w_ready = r_run && !fifo_full &&
                          ((9'(r_wcnt) + 9'(r_wr_ce)) < c_FRAME_LEN9);
                if (r_wr_ce && r_wcnt == c_FRAME_LAST)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                if (fft_edone) begin
`ifdef NC_FRAME_OVERLAP_EN
                    if (r_hist_valid) begin
                        w_state_nxt = REPLAY;
                        w_rep_start = 1'b1;
                    end else begin
                        w_state_nxt = FILL;
                    end
`else
                    w_state_nxt = FILL;
`endif
                end
            end
`ifdef NC_FRAME_OVERLAP_EN
            REPLAY: begin
                if (r_rcnt == c_HDEPTH)
                    w_state_nxt = FILL;
                else
                    w_rep_issue = !fifo_full;
            end
`endif
            default: w_state_nxt = FILL;
        endcase
    end

    assign w_accept   = in_valid && w_ready;
    assign w_edone_ok = (r_state == WAIT) && fft_edone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_wcnt      <= '0;
            r_run       <= 1'b0;
            r_wr_ce     <= 1'b0;
            r_wr_data   <= '0;
            r_full_seen <= 1'b0;
            r_seq       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            r_wr_ce <= w_accept || w_rep_issue;
            if (w_accept)
                r_wr_data <= w_pack;
            else if (w_rep_issue)
                r_wr_data <= w_hist_data;
            if (w_edone_ok)
                r_wcnt <= '0;
            else if (r_wr_ce)
                r_wcnt <= r_wcnt + 1'b1;
            r_full_seen <= (r_state == WAIT) && (r_full_seen || fifo_full) && !fft_edone;
            if (w_edone_ok)
                r_seq <= r_seq + 1'b1;
            if (fifo_error || (fft_edone && r_state != WAIT))
                r_err <= 1'b1;
        end
    end

    assign in_ready  = w_ready;
    assign wr_ce     = r_wr_ce;
    assign wr_data   = r_wr_data;
    assign frame_rdy = (r_state == WAIT) && (r_full_seen || fifo_full);
    assign frame_seq = r_seq;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nc_frame_loader.sv
// ============================================================================
// Module  : tb_nc_frame_loader
// Brief   : Scoreboard bench for nc_frame_loader with randomized samples.
//           Honours NC_FRAME_OVERLAP_EN when defined.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nc_frame_loader;
    import nc_pkg::*;

    localparam int HOP    = 64;
    localparam int HDEPTH = NC_FRAME_LEN - HOP;
`ifdef NC_FRAME_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_error = 1'b0;
    logic        fft_edone = 1'b0;
    logic        wr_ce;
    logic [31:0] wr_data;
    logic        frame_rdy;
    logic [7:0]  frame_seq;
    logic        err;

    nc_frame_loader #(
        .DWIDTH(32), .SWIDTH(16), .FRAME_LEN(NC_FRAME_LEN), .HOP(HOP)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .fifo_full(fifo_full), .fifo_error(fifo_error),
        .fft_edone(fft_edone), .wr_ce(wr_ce), .wr_data(wr_data),
        .frame_rdy(frame_rdy), .frame_seq(frame_seq), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cur_frame[$];
    logic [31:0] hist[$];
    bit          hist_valid_m = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    // Monitor + acceptance observer: all inputs change just after posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_ce) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: got wr_data %0h with nothing expected", wr_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_data", wr_data, e.w);
                    if (e.cyc >= 0)
                        chk("wr_latency", cyc, e.cyc + 1);
                end
            end
            if (in_valid && in_ready) begin
                logic [31:0] w;
                w = nc_pack_sample(in_data);
                sb.push_back('{w, cyc});
                cur_frame.push_back(w);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for sample %0h", d);
            finish_sim();
        end
        step();
        in_valid = 1'b0;
    endtask

    // Model of a legitimate frame completion: the FIFO fills, the FFT finishes.
    task automatic end_frame(input logic [7:0] exp_seq);
        repeat (3) step();
        @(negedge clk);
        chk("wait_in_ready", in_ready, 1'b0);
        chk("wait_frame_rdy_pre", frame_rdy, 1'b0);
        chk("frame_words", cur_frame.size(), NC_FRAME_LEN);
        step();
        fifo_full = 1'b1;
        @(negedge clk);
        chk("frame_rdy_full", frame_rdy, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        step();
        fifo_full = 1'b0;
        fft_edone = 1'b1;
        hist.delete();
        for (int i = NC_FRAME_LEN - HDEPTH; i < cur_frame.size(); i++)
            hist.push_back(cur_frame[i]);
        cur_frame.delete();
        if (OVL && hist_valid_m) begin
            foreach (hist[i]) begin
                sb.push_back('{hist[i], -1});
                cur_frame.push_back(hist[i]);
            end
        end
        hist_valid_m = 1'b1;
        step();
        fft_edone = 1'b0;
        @(negedge clk);
        chk("edone_frame_rdy", frame_rdy, 1'b0);
        chk("edone_frame_seq", frame_seq, exp_seq);
        chk("edone_in_ready", in_ready, OVL ? 1'b0 : 1'b1);
        step();
    endtask

    function automatic int new_samples();
        return (OVL && hist_valid_m) ? HOP : NC_FRAME_LEN;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        finish_sim();
    end

    initial begin
        int n;
        int rst_at;
        logic [15:0] d;

        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_wr_ce", wr_ce, 1'b0);
        chk("rst_wr_data", wr_data, 32'h0);
        chk("rst_frame_rdy", frame_rdy, 1'b0);
        chk("rst_frame_seq", frame_seq, 8'd0);
        chk("rst_err", err, 1'b0);
        step();
        rst = 1'b0;

        // Frame 1: ramp 0..127, back to back.
        for (int k = 0; k < NC_FRAME_LEN; k++)
            send(16'(k), 0);
        end_frame(8'd1);

        // Frame 2: most-negative sample first, random data, stall after 50.
        n = new_samples();
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? 16'h8000 : 16'($urandom);
            send(d, $urandom_range(0, 2));
            if (k == 0) begin
                @(negedge clk);
                chk("pack_8000", wr_data, 32'h8000_0000);
                step();
            end
            if (k == 49) begin
                fifo_full = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1'b0);
                    if (i > 0)
                        chk("stall_wr_ce", wr_ce, 1'b0);
                    step();
                end
                fifo_full = 1'b0;
            end
        end
        end_frame(8'd2);

        // Frame 3: spurious fft_edone after 10 samples.
        n = new_samples();
        @(negedge clk);
        chk("err_before", err, 1'b0);
        step();
        for (int k = 0; k < n; k++) begin
            send(16'($urandom), $urandom_range(0, 1));
            if (k == 9) begin
                fft_edone = 1'b1;
                step();
                fft_edone = 1'b0;
                @(negedge clk);
                chk("bogus_edone_err", err, 1'b1);
                chk("bogus_edone_seq", frame_seq, 8'd2);
                step();
            end
        end
        end_frame(8'd3);
        @(negedge clk);
        chk("err_sticky", err, 1'b1);
        step();

        // Frame 4: reset mid-frame.
        n = new_samples();
        rst_at = (n > 77) ? 77 : n / 2;
        for (int k = 0; k < rst_at; k++)
            send(16'($urandom), 0);
        rst = 1'b1;
        step();
        sb.delete();
        cur_frame.delete();
        hist.delete();
        hist_valid_m = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_wr_ce", wr_ce, 1'b0);
        chk("mid_rst_wr_data", wr_data, 32'h0);
        chk("mid_rst_frame_rdy", frame_rdy, 1'b0);
        chk("mid_rst_frame_seq", frame_seq, 8'd0);
        chk("mid_rst_err", err, 1'b0);
        step();
        rst = 1'b0;

        // Frame 5: fresh full frame with extremes and a FIFO overflow pulse.
        for (int k = 0; k < NC_FRAME_LEN; k++) begin
            case (k)
                0:       d = 16'h7fff;
                1:       d = 16'h8001;
                2:       d = 16'hffff;
                default: d = 16'($urandom);
            endcase
            send(d, $urandom_range(0, 2));
            if (k == 20) begin
                @(negedge clk);
                chk("err_before_fifo_error", err, 1'b0);
                step();
                fifo_error = 1'b1;
                step();
                fifo_error = 1'b0;
                @(negedge clk);
                chk("fifo_error_err", err, 1'b1);
                step();
            end
        end
        end_frame(8'd1);

        repeat (HDEPTH + 8) step();
        chk("sb_drained", sb.size(), OVL ? HDEPTH - HDEPTH : 0);
        finish_sim();
    end

endmodule

`default_nettype wire
